// File: rtl/eqn_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package eqn_sweep_pkg;

    localparam int unsigned N_IN_DEF = 3;
    localparam int unsigned N_VEC    = 2 ** N_IN_DEF;

    // Reference table for Y = AB + AC + ABC, index = {A,B,C}
    localparam logic [N_VEC-1:0] DEFAULT_EXPECTED = N_VEC'(8'hE0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/eqn_sweep_ctrl_settle_timer.sv
// Loadable settle down-counter; a load of 0 is stretched to 1 so every vector settles at least one cycle.
module settle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         expire_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= (load_val == '0) ? W'(1) : load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Last settle cycle: the controller moves to SAMPLE on the following edge
    assign expire_c = (count == W'(1));

endmodule

// File: rtl/eqn_sweep_ctrl.sv
// Sweeps every input vector of an external combinational circuit, captures its truth table
// and compares it against a latched reference.
module eqn_sweep_ctrl
    import eqn_sweep_pkg::*;
#(
    parameter int unsigned N_IN     = 3,
    parameter int unsigned SETTLE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SETTLE_W-1:0]     settle_cycles,
    input  logic [(2**N_IN)-1:0]    expected,
    input  logic                    y_in,
    output logic [N_IN-1:0]         vec_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(2**N_IN)-1:0]    truth_table,
    output logic [N_IN-1:0]         fail_idx
);

    localparam int unsigned NV = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    sweep_state_e        state_q, state_d;
    logic [NV-1:0]       exp_q, exp_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [N_IN-1:0]     vec_d, fail_d;
    logic [NV-1:0]       tt_d;
    logic                busy_d, done_d, pass_d;

    logic                load_c, clr_c, expire_c;
    logic [SETTLE_W-1:0] load_val_c;
    logic [SETTLE_W-1:0] tmr_count_unused;

    logic [NV-1:0]       tt_fin_c, diff_c;
    logic [N_IN-1:0]     first_c;

    settle_timer #(
        .W (SETTLE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .clr      (clr_c),
        .load_val (load_val_c),
        .count    (tmr_count_unused),
        .expire_c (expire_c)
    );

    // Table as it will stand after the current sample, and its lowest mismatching index
    always_comb begin
        tt_fin_c          = truth_table;
        tt_fin_c[vec_out] = y_in;
        diff_c            = tt_fin_c ^ exp_q;
        first_c           = '0;
        for (int i = int'(NV) - 1; i >= 0; i--) begin
            if (diff_c[i]) first_c = N_IN'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        settle_d   = settle_q;
        vec_d      = vec_out;
        busy_d     = busy;
        done_d     = 1'b0;
        pass_d     = pass;
        tt_d       = truth_table;
        fail_d     = fail_idx;
        load_c     = 1'b0;
        clr_c      = 1'b0;
        load_val_c = (state_q == IDLE) ? settle_cycles : settle_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    exp_d    = expected;
                    settle_d = settle_cycles;
                    tt_d     = '0;
                    vec_d    = '0;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    fail_d   = '0;
                    load_c   = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    clr_c   = 1'b1;
                end else if (expire_c) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    clr_c   = 1'b1;
                end else if (vec_out == LAST_VEC) begin
                    tt_d    = tt_fin_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (diff_c == '0);
                    fail_d  = (diff_c == '0) ? '0 : first_c;
                    state_d = DONE;
                end else begin
                    tt_d    = tt_fin_c;
                    vec_d   = vec_out + N_IN'(1);
                    load_c  = 1'b1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            settle_q    <= '0;
            vec_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            truth_table <= '0;
            fail_idx    <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            settle_q    <= settle_d;
            vec_out     <= vec_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            truth_table <= tt_d;
            fail_idx    <= fail_d;
        end
    end

endmodule

// File: tb/tb_eqn_sweep_ctrl.sv
// Self-checking bench: table-driven sweeps against Y = AB + AC + ABC plus abort/reset corner cases.
module tb_eqn_sweep_ctrl;
    import eqn_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] settle_cycles;
    logic [7:0] expected;
    logic       y_in;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] truth_table;
    logic [2:0] fail_idx;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    eqn_sweep_ctrl #(
        .N_IN     (3),
        .SETTLE_W (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .settle_cycles (settle_cycles),
        .expected      (expected),
        .y_in          (y_in),
        .vec_out       (vec_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .truth_table   (truth_table),
        .fail_idx      (fail_idx)
    );

    // Controlled equation circuit, vec_out = {A,B,C}
    wire eq_a = vec_out[2];
    wire eq_b = vec_out[1];
    wire eq_c = vec_out[0];
    assign y_in = (eq_a & eq_b) | (eq_a & eq_c) | (eq_a & eq_b & eq_c);

    typedef struct {
        logic [3:0] s;
        logic [7:0] e;
        int         restart_at;
        int         abort_at;
        logic       aborts;
        logic [7:0] tt;
        logic       pass;
        logic [2:0] fidx;
        int         lat;
    } row_t;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [2:0] fidx;
        int         lat;
    } res_t;

    res_t sb[$];
    row_t rows[10];

    int   got_lat, got_ndone;
    logic busy_k1, busy_at_done, ab_busy, ab_pass;
    logic [2:0] ab_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Drives one start at the current cycle and watches for a fixed window
    task automatic run_sweep(input row_t r);
        int limit;
        limit         = r.aborts ? r.abort_at + 20 : r.lat + 5;
        settle_cycles = r.s;
        expected      = r.e;
        start         = 1'b1;
        got_lat       = -1;
        got_ndone     = 0;
        busy_at_done  = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start   = 1'b0;
                busy_k1 = busy;
            end
            if (done) begin
                got_ndone++;
                if (got_lat < 0) begin
                    got_lat      = k;
                    busy_at_done = busy;
                end
            end
            if (r.aborts && k == r.abort_at + 1) begin
                ab_busy = busy;
                ab_vec  = vec_out;
                ab_pass = pass;
            end
            if (k == r.restart_at) begin
                start         = 1'b1;
                settle_cycles = ~r.s;
                expected      = ~r.e;
            end
            if (r.restart_at > 0 && k == r.restart_at + 1) start = 1'b0;
            if (k == r.abort_at) abort = 1'b1;
            if (r.abort_at > 0 && k == r.abort_at + 1) abort = 1'b0;
        end
    endtask

    task automatic run_row(input row_t r);
        res_t x;
        if (!r.aborts) begin
            x.tt = r.tt; x.pass = r.pass; x.fidx = r.fidx; x.lat = r.lat;
            sb.push_back(x);
        end
        run_sweep(r);
        chk("busy_rise", 32'(busy_k1), 32'd1);
        if (r.aborts) begin
            chk("abort_no_done", 32'(got_ndone), 32'd0);
            chk("abort_busy",    32'(ab_busy),   32'd0);
            chk("abort_vec",     32'(ab_vec),    32'd0);
            chk("abort_pass",    32'(ab_pass),   32'd0);
        end else begin
            chk("done_count", 32'(got_ndone), 32'd1);
            chk("busy_at_done", 32'(busy_at_done), 32'd0);
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("latency",     32'(got_lat),     32'(x.lat));
                chk("truth_table", 32'(truth_table), 32'(x.tt));
                chk("pass",        32'(pass),        32'(x.pass));
                chk("fail_idx",    32'(fail_idx),    32'(x.fidx));
            end
        end
    endtask

    initial begin
        //          s      e      rst  abt  ab     tt     pass  fidx lat
        rows[0] = '{4'd2,  DEFAULT_EXPECTED, 0, 0, 1'b0, 8'hE0, 1'b1, 3'd0, 25};
        rows[1] = '{4'd2,  8'hE8, 0,  0,  1'b0, 8'hE0, 1'b0, 3'd3, 25};
        rows[2] = '{4'd0,  8'hE0, 0,  0,  1'b0, 8'hE0, 1'b1, 3'd0, 17};
        rows[3] = '{4'd2,  8'hE0, 13, 0,  1'b0, 8'hE0, 1'b1, 3'd0, 25};
        rows[4] = '{4'd2,  8'hE0, 0,  16, 1'b1, 8'h00, 1'b0, 3'd0, 0};
        rows[5] = '{4'd2,  8'hE0, 0,  0,  1'b0, 8'hE0, 1'b1, 3'd0, 25};
        rows[6] = '{4'd1,  8'h00, 0,  0,  1'b0, 8'hE0, 1'b0, 3'd5, 17};
        rows[7] = '{4'd3,  8'hE1, 0,  0,  1'b0, 8'hE0, 1'b0, 3'd0, 33};
        rows[8] = '{4'd15, 8'h60, 0,  0,  1'b0, 8'hE0, 1'b0, 3'd7, 129};
        rows[9] = '{4'd2,  8'hE0, 0,  25, 1'b0, 8'hE0, 1'b1, 3'd0, 25};

        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        settle_cycles = '0; expected = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tt",   32'(truth_table), 32'd0);
        chk("rst_fidx", 32'(fail_idx), 32'd0);
        chk("rst_vec",  32'(vec_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_row(rows[i]);

        // Start and abort together in IDLE: start is dropped, previous table kept
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        got_ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) got_ndone++;
        end
        chk("start_abort_no_done", 32'(got_ndone), 32'd0);
        chk("start_abort_tt_kept", 32'(truth_table), 32'hE0);

        // Asynchronous reset in the first settle cycle of vector 6
        settle_cycles = 4'd2; expected = 8'hE0; start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
        end
        chk("pre_rst_vec", 32'(vec_out), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        chk("arst_tt",   32'(truth_table), 32'd0);
        chk("arst_fidx", 32'(fail_idx), 32'd0);
        chk("arst_vec",  32'(vec_out), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
        run_row(rows[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
